// File: rtl/apb_pkg.sv
// apb_pkg: shared FSM state encoding, peripheral region and default data constants
package apb_pkg;
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} apb_state_e;
    localparam logic [3:0]  PERIPH_REGION = 4'h1;
    localparam logic [31:0] DATA_ZERO     = 32'h0000_0000;
    localparam logic [31:0] DATA_TIMEOUT  = 32'hDEAD_BEEF;
endpackage

// File: rtl/apb_decoder.sv
// apb_decoder: maps a byte address onto a one-hot APB slave select
import apb_pkg::*;
module apb_decoder #(
    parameter int NUM_SLV = 4
) (
    input  logic [31:0]        addr_i,
    output logic [NUM_SLV-1:0] sel_o,
    output logic               hit_o
);
    always_comb begin
        sel_o = '0;
        for (int i = 0; i < NUM_SLV; i++)
            sel_o[i] = (addr_i[31:28] == PERIPH_REGION) && (addr_i[15:12] == 4'(i));
    end
    assign hit_o = |sel_o;
endmodule

// File: rtl/apb_master.sv
// apb_master: CPU data-bus to APB bridge with IDLE/SETUP/ACCESS/RESP FSM.
// Define APB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYC cycles without PREADY.
import apb_pkg::*;
module apb_master #(
    parameter int NUM_SLV     = 4,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    busReq,
    input  logic                    busWe,
    input  logic [31:0]             busAddr,
    input  logic [31:0]             busWData,
    output logic [31:0]             busRData,
    output logic                    busReady,
    output logic                    busErr,
    output logic [31:0]             PADDR,
    output logic                    PWRITE,
    output logic [31:0]             PWDATA,
    output logic                    PENABLE,
    output logic [NUM_SLV-1:0]      PSEL,
    input  logic [NUM_SLV-1:0][31:0] PRDATA,
    input  logic [NUM_SLV-1:0]      PREADY
);
    apb_state_e          state_q;
    logic [31:0]         paddr_q, pwdata_q, rdata_q;
    logic                pwrite_q, penable_q, ready_q, err_q;
    logic [NUM_SLV-1:0]  psel_q, dec_sel;
    logic                dec_hit, slv_ready;
    logic [31:0]         slv_rdata;

    apb_decoder #(.NUM_SLV(NUM_SLV)) u_dec (
        .addr_i (busAddr),
        .sel_o  (dec_sel),
        .hit_o  (dec_hit)
    );

    // Only the selected slave's handshake is observed
    always_comb begin
        slv_rdata = '0;
        for (int i = 0; i < NUM_SLV; i++)
            slv_rdata = slv_rdata | (psel_q[i] ? PRDATA[i] : '0);
    end
    assign slv_ready = |(PREADY & psel_q);

`ifdef APB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] cnt_q;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            paddr_q   <= DATA_ZERO;
            pwdata_q  <= DATA_ZERO;
            rdata_q   <= DATA_ZERO;
            pwrite_q  <= 1'b0;
            penable_q <= 1'b0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
            psel_q    <= '0;
`ifdef APB_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: if (busReq) begin
                    paddr_q  <= busAddr;
                    pwrite_q <= busWe;
                    pwdata_q <= busWData;
                    if (dec_hit) begin
                        psel_q  <= dec_sel;
                        state_q <= SETUP;
                    end else begin
                        ready_q <= 1'b1;
                        err_q   <= 1'b1;
                        rdata_q <= DATA_ZERO;
                        state_q <= RESP;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
`ifdef APB_TIMEOUT_EN
                    cnt_q     <= '0;
`endif
                    state_q   <= ACCESS;
                end
                ACCESS: if (slv_ready) begin
                    psel_q    <= '0;
                    penable_q <= 1'b0;
                    ready_q   <= 1'b1;
                    err_q     <= 1'b0;
                    rdata_q   <= pwrite_q ? DATA_ZERO : slv_rdata;
                    state_q   <= RESP;
                end
`ifdef APB_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
                    psel_q    <= '0;
                    penable_q <= 1'b0;
                    ready_q   <= 1'b1;
                    err_q     <= 1'b1;
                    rdata_q   <= DATA_TIMEOUT;
                    state_q   <= RESP;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
`endif
                RESP: begin
                    ready_q <= 1'b0;
                    err_q   <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busRData = rdata_q;
    assign busReady = ready_q;
    assign busErr   = err_q;
    assign PADDR    = paddr_q;
    assign PWRITE   = pwrite_q;
    assign PWDATA   = pwdata_q;
    assign PENABLE  = penable_q;
    assign PSEL     = psel_q;
endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: table-driven directed checks of apb_master plus back-to-back and reset sequences
module tb_apb_master;
    logic             clk = 1'b0;
    logic             reset;
    logic             busReq, busWe;
    logic [31:0]      busAddr, busWData, busRData, PADDR, PWDATA;
    logic             busReady, busErr, PWRITE, PENABLE;
    logic [3:0]       PSEL, PREADY;
    logic [3:0][31:0] PRDATA;
    int checks = 0;
    int errors = 0;

    apb_master #(.NUM_SLV(4), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .reset(reset), .busReq(busReq), .busWe(busWe), .busAddr(busAddr),
        .busWData(busWData), .busRData(busRData), .busReady(busReady), .busErr(busErr),
        .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA), .PENABLE(PENABLE),
        .PSEL(PSEL), .PRDATA(PRDATA), .PREADY(PREADY)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr, wdata, prdata;
        int          slv, dly;
        logic [3:0]  e_psel;
        int          e_lat;
        logic        e_err;
        logic [31:0] e_rdata;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input vec_t v);
        logic [3:0] m, seen;
        int acc, lat;
        bit done, setup_seen;
        m = 4'(1 << v.slv);
        for (int i = 0; i < 4; i++) PRDATA[i] = 32'hC000_0000 | 32'(i);
        PRDATA[v.slv] = v.prdata;
        PREADY = ~m;
        busReq = 1'b1; busWe = v.we; busAddr = v.addr; busWData = v.wdata;
        acc = 0; lat = 0; seen = '0; done = 0; setup_seen = 0;
        while (!done && lat < 40) begin
            step();
            lat++;
            seen |= PSEL;
            if ((PSEL & (PSEL - 4'd1)) != 0) chk("psel_onehot", 32'(PSEL), 32'(PSEL & -PSEL));
            if (PSEL != 0 && !PENABLE && !setup_seen) begin
                setup_seen = 1;
                chk("setup_pwdata", PWDATA, v.wdata);
                chk("setup_pwrite", 32'(PWRITE), 32'(v.we));
            end
            if (PENABLE) begin
                acc++;
                chk("access_paddr", PADDR, v.addr);
            end
            if (busReady) done = 1;
            PREADY = ~m | ((PENABLE && acc >= v.dly + 1) ? m : 4'b0);
        end
        busReq = 1'b0;
        PREADY = ~m;
        chk("latency", 32'(lat), 32'(v.e_lat));
        chk("bus_err", 32'(busErr), 32'(v.e_err));
        chk("bus_rdata", busRData, v.e_rdata);
        chk("psel_seen", 32'(seen), 32'(v.e_psel));
        step();
        chk("ready_single", 32'(busReady), 32'd0);
    endtask

    vec_t vt[$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; busReq = 1'b0; busWe = 1'b0; busAddr = '0; busWData = '0;
        PREADY = '0; PRDATA = '0;
        //       we    addr          wdata         prdata        slv dly psel    lat err rdata
        vt.push_back('{1'b1, 32'h1000_2004, 32'hA5A5_5A5A, 32'hFFFF_0000, 2, 0, 4'b0100, 3, 1'b0, 32'h0});
        vt.push_back('{1'b0, 32'h1000_1000, 32'h0,         32'h1234_5678, 1, 3, 4'b0010, 6, 1'b0, 32'h1234_5678});
        vt.push_back('{1'b0, 32'h2000_0000, 32'h0,         32'h5555_5555, 0, 0, 4'b0000, 1, 1'b1, 32'h0});
        vt.push_back('{1'b0, 32'h1000_7000, 32'h0,         32'h5555_5555, 0, 0, 4'b0000, 1, 1'b1, 32'h0});
        vt.push_back('{1'b0, 32'h1000_0000, 32'h0,         32'h0BAD_F00D, 0, 1, 4'b0001, 4, 1'b0, 32'h0BAD_F00D});
        vt.push_back('{1'b0, 32'h1000_3FFC, 32'h0,         32'h8765_4321, 3, 0, 4'b1000, 3, 1'b0, 32'h8765_4321});
        vt.push_back('{1'b1, 32'h1000_3000, 32'h0F0F_1234, 32'h7777_7777, 3, 2, 4'b1000, 5, 1'b0, 32'h0});
        vt.push_back('{1'b0, 32'h0000_1000, 32'h0,         32'h5555_5555, 1, 0, 4'b0000, 1, 1'b1, 32'h0});
        step(); step();
        chk("rst_psel", 32'(PSEL), 32'd0);
        chk("rst_penable", 32'(PENABLE), 32'd0);
        chk("rst_ready", 32'(busReady), 32'd0);
        chk("rst_paddr", PADDR, 32'd0);
        chk("rst_rdata", busRData, 32'd0);
        @(negedge clk) reset = 1'b1;
        step();
        foreach (vt[k]) run(vt[k]);

        // back-to-back reads: slave 0 then slave 3 with request held
        PREADY = 4'hF;
        PRDATA[0] = 32'h1111_1111; PRDATA[3] = 32'h3333_3333;
        busReq = 1'b1; busWe = 1'b0; busAddr = 32'h1000_0000;
        step(); chk("b2b_setup1_psel", 32'(PSEL), 32'b0001); chk("b2b_setup1_en", 32'(PENABLE), 32'd0);
        step(); chk("b2b_access1_en", 32'(PENABLE), 32'd1);
        step(); chk("b2b_resp1_ready", 32'(busReady), 32'd1); chk("b2b_resp1_rdata", busRData, 32'h1111_1111);
        busAddr = 32'h1000_3000;
        step(); chk("b2b_idle_psel", 32'(PSEL), 32'd0); chk("b2b_idle_ready", 32'(busReady), 32'd0);
        step(); chk("b2b_setup2_psel", 32'(PSEL), 32'b1000); chk("b2b_setup2_en", 32'(PENABLE), 32'd0);
        step(); chk("b2b_access2_en", 32'(PENABLE), 32'd1);
        step(); chk("b2b_resp2_ready", 32'(busReady), 32'd1); chk("b2b_resp2_rdata", busRData, 32'h3333_3333);
        busReq = 1'b0;
        step();

        // reset pulsed during ACCESS
        PREADY = 4'h0;
        busReq = 1'b1; busWe = 1'b1; busAddr = 32'h1000_1000; busWData = 32'hCAFE_0001;
        step(); step();
        chk("mid_access_en", 32'(PENABLE), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("arst_psel", 32'(PSEL), 32'd0);
        chk("arst_penable", 32'(PENABLE), 32'd0);
        chk("arst_pwrite", 32'(PWRITE), 32'd0);
        chk("arst_paddr", PADDR, 32'd0);
        chk("arst_pwdata", PWDATA, 32'd0);
        chk("arst_ready", 32'(busReady), 32'd0);
        chk("arst_err", 32'(busErr), 32'd0);
        busReq = 1'b0;
        step(); step();
        chk("arst_no_ready", 32'(busReady), 32'd0);
        @(negedge clk) reset = 1'b1;
        step();
        chk("post_rst_idle_ready", 32'(busReady), 32'd0);
        run(vt[1]);
`ifdef APB_TIMEOUT_EN
        run('{1'b0, 32'h1000_2000, 32'h0, 32'h4444_4444, 2, 1000, 4'b0100, 18, 1'b1, 32'hDEAD_BEEF});
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
